mem_stream_reader: RTL and testbench

- Sequencer placed between the program RAM (16-bit x 32, synchronous read, one-cycle latency) and downstream consumers inside chip.
- On a start command it walks a range of RAM addresses, drives the RAM's cs and address, and captures the read data.
- It presents each word on a valid/ready stream and absorbs consumer backpressure in a 2-entry output FIFO, so no read is ever lost.

---
 rtl/mem_stream_reader.sv | 111 +++++++++++
 tb/tb_mem_stream_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Walks a range of program-RAM addresses and streams the words out on valid/ready,
// using a 2-entry FIFO plus an in-flight credit so backpressure never drops a read.
module mem_stream_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_cs,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [1:0]        occ;
  logic              pop;
  logic              issue;
  logic [ADDR_W-1:0] addr_next;

  // A read may only issue if its word is guaranteed a FIFO slot when it lands.
  assign occ       = count + {1'b0, inflight};
  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign issue     = (state == RUN) && (remaining != '0) &&
                     ((occ < 2'd2) || ((occ == 2'd2) && pop));
  assign ram_cs    = issue;
  assign ram_addr  = addr;
  assign busy      = (state != IDLE);
  assign addr_next = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr      <= start_addr;
              remaining <= length;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr      <= addr_next;
            remaining <= remaining - 1'b1;
            if (remaining == {{ADDR_W{1'b0}}, 1'b1}) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((count == 2'd0) && !inflight && (remaining == '0)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM answers one cycle after ram_cs, so the in-flight flag marks the capture edge.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      inflight <= issue;
      if (inflight) begin
        fifo_mem[wr_ptr] <= ram_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized self-checking bench for mem_stream_reader: an address/data queue model
// of each command is compared against the RAM port and the output stream every cycle.
module tb_mem_stream_reader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst_async;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              ram_cs;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  logic [DATA_W-1:0] mem [DEPTH];
  int                total = 0;
  int                bad = 0;
  int                addr_q[$];
  logic [DATA_W-1:0] data_q[$];
  logic [DATA_W-1:0] got_q[$];
  int                issued = 0;
  int                delivered = 0;
  int                done_cnt = 0;
  int                held;
  int                ready_mode = 0;
  int                phase = 0;

  mem_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_async(rst_async), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .ram_cs(ram_cs), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_cs) ram_rdata <= mem[ram_addr];

  // Consumer: always ready, a 1,0,0,1 pattern, or random backpressure.
  always @(posedge clk) begin
    #1;
    phase = phase + 1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Every cycle: each read must hit the next address of the command, the FIFO head must
  // be the next expected word, and at most two words may be held between RAM and consumer.
  always @(negedge clk) begin
    if (!rst_async) begin
      held = issued - delivered;
      if (ram_cs) begin
        if (addr_q.size() == 0) flag_fail("spurious_ram_cs");
        else check_output("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
        if (!(out_valid && out_ready)) check_output("credit_limit", 32'(held < 2), 32'd1);
        issued++;
      end
      if (out_valid) begin
        if (data_q.size() == 0) flag_fail("spurious_out_valid");
        else begin
          check_output("out_data", 32'(out_data), 32'(data_q[0]));
          if (out_ready) begin
            void'(data_q.pop_front());
            got_q.push_back(out_data);
            delivered++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        check_output("done_with_busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic start_cmd(input int a, input int len);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = ADDR_W'(a);
    length     = (ADDR_W + 1)'(len);
    for (int i = 0; i < len; i++) begin
      addr_q.push_back((a + i) % DEPTH);
      data_q.push_back(mem[(a + i) % DEPTH]);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) flag_fail({name, "_done_timeout"});
    check_output({name, "_words_left"}, 32'(data_q.size()), 32'd0);
  endtask

  task automatic apply_stimulus(input string name, input int a, input int len, input int mode);
    ready_mode = mode;
    got_q.delete();
    done_cnt = 0;
    start_cmd(a, len);
    wait_done(name);
    repeat (3) @(negedge clk);
    check_output({name, "_done_count"}, 32'(done_cnt), 32'd1);
    check_output({name, "_busy_after"}, 32'(busy), 32'd0);
    check_output({name, "_word_count"}, 32'(got_q.size()), 32'(len));
  endtask

  initial begin
    int first_valid;
    int done_at;
    int n;
    logic [DATA_W-1:0] exp_lit [4];

    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hA000 + 16'(i);
    rst_async  = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    out_ready  = 1'b1;
    #3;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_ram_cs", 32'(ram_cs), 32'd0);
    check_output("reset_ram_addr", 32'(ram_addr), 32'd0);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_async = 1'b0;

    // Latency and timing of the first command, pinned to hand-derived cycle numbers.
    ready_mode = 0;
    got_q.delete();
    done_cnt = 0;
    first_valid = -1;
    done_at = -1;
    start_cmd(0, 4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid && first_valid < 0) first_valid = c;
      if (done) done_at = c;
    end
    check_output("t1_first_valid_cycle", 32'(first_valid), 32'd2);
    check_output("t1_done_cycle", 32'(done_at), 32'd7);
    check_output("t1_done_count", 32'(done_cnt), 32'd1);
    check_output("t1_word_count", 32'(got_q.size()), 32'd4);
    exp_lit = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check_output("t1_word_literal", 32'(got_q[i]), 32'(exp_lit[i]));

    apply_stimulus("wrap", 30, 4, 0);
    exp_lit = '{16'hA01E, 16'hA01F, 16'hA000, 16'hA001};
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check_output("wrap_word_literal", 32'(got_q[i]), 32'(exp_lit[i]));

    apply_stimulus("stall", 0, 8, 1);

    // Zero-length command completes with a lone done pulse.
    ready_mode = 0;
    done_cnt = 0;
    start_cmd(3, 0);
    @(negedge clk);
    check_output("len0_done", 32'(done), 32'd1);
    check_output("len0_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_output("len0_done_count", 32'(done_cnt), 32'd1);
    check_output("len0_out_valid", 32'(out_valid), 32'd0);

    apply_stimulus("full", 5, 32, 0);
    if (got_q.size() == 32) begin
      check_output("full_first_literal", 32'(got_q[0]), 32'h0000A005);
      check_output("full_last_literal", 32'(got_q[31]), 32'h0000A004);
    end

    // Asynchronous reset in the middle of a six-word command.
    ready_mode = 0;
    got_q.delete();
    start_cmd(10, 6);
    n = 0;
    while (got_q.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() < 3) flag_fail("reset_mid_wait_timeout");
    #2;
    rst_async = 1'b1;
    #1;
    check_output("rstmid_busy", 32'(busy), 32'd0);
    check_output("rstmid_ram_cs", 32'(ram_cs), 32'd0);
    check_output("rstmid_ram_addr", 32'(ram_addr), 32'd0);
    check_output("rstmid_out_valid", 32'(out_valid), 32'd0);
    check_output("rstmid_out_data", 32'(out_data), 32'd0);
    check_output("rstmid_done", 32'(done), 32'd0);
    addr_q.delete();
    data_q.delete();
    issued = 0;
    delivered = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_async = 1'b0;
    apply_stimulus("after_reset", 0, 2, 0);
    if (got_q.size() == 2) begin
      check_output("after_reset_w0", 32'(got_q[0]), 32'h0000A000);
      check_output("after_reset_w1", 32'(got_q[1]), 32'h0000A001);
    end

    // A second start while busy must be ignored.
    ready_mode = 1;
    got_q.delete();
    done_cnt = 0;
    start_cmd(0, 5);
    repeat (2) @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = ADDR_W'(20);
    length     = (ADDR_W + 1)'(9);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("repulse");
    repeat (3) @(negedge clk);
    check_output("repulse_word_count", 32'(got_q.size()), 32'd5);
    check_output("repulse_done_count", 32'(done_cnt), 32'd1);

    // Random memory contents, ranges, lengths and backpressure.
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    for (int k = 0; k < 20; k++)
      apply_stimulus("random", $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
